mux_2to1: RTL and testbench



---
 rtl/mux_2to1_pkg.sv | 12 +
 rtl/d_ff.sv | 23 ++
 rtl/mux_2to1.sv | 34 +++
 tb/tb_mux_2to1.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_2to1_pkg.sv
// Shared gate-library constants for the gate-level CPU cells.
// Delays are expressed in 10 ps time units.
`timescale 10ps/1ps
package mux_2to1_pkg;

    // Default propagation delay of every primitive gate (5 x 10 ps = 50 ps).
    localparam int GATE_DELAY_DEFAULT = 5;

    // Worst-case input-to-output depth of the 2:1 mux (NOT, AND, OR).
    localparam int MUX_DEPTH = 3;

endpackage : mux_2to1_pkg

// File: rtl/d_ff.sv
// Standard flop cell: single clock, synchronous active-high reset to 0.
`timescale 10ps/1ps
module d_ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic q_r;

    // Capture d each rising edge; reset clears the flop synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= 1'b0;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule : d_ff

// File: rtl/mux_2to1.sv
// Single-bit 2:1 mux leaf cell built from delayed gate primitives,
// with a flopped copy of the result for downstream pipeline stages.
`timescale 10ps/1ps
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int GATE_DELAY = GATE_DELAY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in,
    input  logic       sel,
    output logic       out,
    output logic       out_q
);

    logic sel_n_s;
    logic leg0_s;
    logic leg1_s;

    // AND gating keeps an X on the unselected leg from reaching out.
    not #(GATE_DELAY) g_not  (sel_n_s, sel);
    and #(GATE_DELAY) g_and0 (leg0_s, in[0], sel_n_s);
    and #(GATE_DELAY) g_and1 (leg1_s, in[1], sel);
    or  #(GATE_DELAY) g_or   (out, leg1_s, leg0_s);

    d_ff u_out_ff (
        .clk   (clk),
        .reset (reset),
        .d     (out),
        .q     (out_q)
    );

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: gate timing, exhaustive truth table,
// registered path, reset behaviour, X isolation and randomized traffic.
`timescale 10ps/1ps
module tb_mux_2to1;

    logic       clk;
    logic       reset;
    logic [1:0] in;
    logic       sel;
    logic       out;
    logic       out_q;

    int n_checks = 0;
    int n_pass   = 0;

    mux_2to1 #(.GATE_DELAY(5)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .sel   (sel),
        .out   (out),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference: a 2:1 mux picks in[sel].
    function automatic logic ref_mux(input logic [1:0] d, input logic s);
        return s ? d[1] : d[0];
    endfunction

    task automatic test_reset();
        reset = 1'b1; in = 2'b11; sel = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_q !== 1'b0) $display("FAIL reset_out_q: got %b expected 0", out_q);
        else n_pass++;
        n_checks++;
        if (out !== 1'b1) $display("FAIL reset_out_live: got %b expected 1", out);
        else n_pass++;
    endtask

    task automatic test_static_select();
        @(negedge clk);
        reset = 1'b0; in = 2'b10; sel = 1'b0;
        #15.1;
        n_checks++;
        if (out !== 1'b0) $display("FAIL static_sel0: got %b expected 0", out);
        else n_pass++;
        sel = 1'b1;
        #15.1;
        n_checks++;
        if (out !== 1'b1) $display("FAIL static_sel1: got %b expected 1", out);
        else n_pass++;
    endtask

    task automatic test_exhaustive();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            in = v[2:1]; sel = v[0];
            #16;
            n_checks++;
            if (out !== ref_mux(v[2:1], v[0]))
                $display("FAIL exhaustive in=%b sel=%b: got %b expected %b",
                         v[2:1], v[0], out, ref_mux(v[2:1], v[0]));
            else n_pass++;
        end
    endtask

    task automatic test_delay();
        in = 2'b01; sel = 1'b0;
        #20;
        sel = 1'b1;
        #9.9;
        n_checks++;
        if (out !== 1'b1) $display("FAIL delay_sel_hold: got %b expected 1", out);
        else n_pass++;
        #5.2;
        n_checks++;
        if (out !== 1'b0) $display("FAIL delay_sel_settle: got %b expected 0", out);
        else n_pass++;
        #20;
        in = 2'b11;
        #9.9;
        n_checks++;
        if (out !== 1'b0) $display("FAIL delay_in_early: got %b expected 0", out);
        else n_pass++;
        #0.2;
        n_checks++;
        if (out !== 1'b1) $display("FAIL delay_in_exact: got %b expected 1", out);
        else n_pass++;
    endtask

    task automatic test_registered();
        @(negedge clk);
        reset = 1'b0; in = 2'b10; sel = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_q !== 1'b1) $display("FAIL reg_sel1: got %b expected 1", out_q);
        else n_pass++;
        #10;
        sel = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_q !== 1'b0) $display("FAIL reg_sel0: got %b expected 0", out_q);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        reset = 1'b0; in = 2'b11; sel = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_q !== 1'b1) $display("FAIL midrst_pre: got %b expected 1", out_q);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_q !== 1'b0) $display("FAIL midrst_hold%0d: got %b expected 0", c, out_q);
            else n_pass++;
            n_checks++;
            if (out !== 1'b1) $display("FAIL midrst_out%0d: got %b expected 1", c, out);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_q !== 1'b1) $display("FAIL midrst_release: got %b expected 1", out_q);
        else n_pass++;
    endtask

    task automatic test_x_isolation();
        @(negedge clk);
        reset = 1'b0; in = {1'b1, 1'bx}; sel = 1'b1;
        #20;
        n_checks++;
        if (out !== 1'b1) $display("FAIL xiso_out: got %b expected 1", out);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_q !== 1'b1) $display("FAIL xiso_out_q: got %b expected 1", out_q);
        else n_pass++;
    endtask

    task automatic test_random();
        logic exp_out;
        logic exp_q;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in    = 2'($urandom_range(3, 0));
            sel   = 1'($urandom_range(1, 0));
            reset = ($urandom_range(7, 0) == 0);
            exp_out = ref_mux(in, sel);
            exp_q   = reset ? 1'b0 : exp_out;
            #20;
            n_checks++;
            if (out !== exp_out)
                $display("FAIL rand_out[%0d]: got %b expected %b", i, out, exp_out);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (out_q !== exp_q)
                $display("FAIL rand_out_q[%0d]: got %b expected %b", i, out_q, exp_q);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in = 2'b00; sel = 1'b0;
        test_reset();
        test_static_select();
        test_exhaustive();
        test_delay();
        test_registered();
        test_reset_midstream();
        test_x_isolation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_2to1
